// File: rtl/load_register.sv
// rtl/load_register.sv - parallel-load storage register with load enable
//
// Ports:
//   Clk     - rising-edge clock, the only clock
//   Reset   - asynchronous active-low reset; forces DataOut to RESET_VALUE
//   DataIn  - WIDTH-bit parallel data to capture
//   Load    - active-high load enable, sampled on rising Clk
//   DataOut - WIDTH-bit registered contents, driven directly by the flops

module load_register #(
    parameter int                 WIDTH       = 8,
    parameter logic [WIDTH-1:0]   RESET_VALUE = {WIDTH{1'b0}}
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic [WIDTH-1:0] DataIn,
    input  logic             Load,
    output logic [WIDTH-1:0] DataOut
);

    // Reset takes priority over Load; the enable is a data-path mux that
    // recirculates DataOut when Load is low, so the clock is never gated.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            DataOut <= RESET_VALUE;
        end else if (Load) begin
            DataOut <= DataIn;
        end
    end

endmodule

// File: tb/tb_load_register.sv
// tb/tb_load_register.sv - directed and randomized checks for load_register

`timescale 1ns/1ps

module tb_load_register;

    logic       Clk;
    logic       Reset;
    logic [7:0] DataIn;
    logic       Load;
    logic [7:0] DataOut;

    int n_cmp;
    int n_bad;

    load_register #(
        .WIDTH       (8),
        .RESET_VALUE (8'h00)
    ) dut (
        .Clk     (Clk),
        .Reset   (Reset),
        .DataIn  (DataIn),
        .Load    (Load),
        .DataOut (DataOut)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic after_pos();
        @(posedge Clk);
        #1;
    endtask

    task automatic test_reset();
        Reset  = 1'b1;
        DataIn = 8'hA5;
        Load   = 1'b1;
        #1;
        Reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            #2;
            n_cmp++;
            if (DataOut !== 8'h00) begin
                n_bad++;
                $display("FAIL reset_hold t=%0t actual=%h required=%h", $time, DataOut, 8'h00);
            end
        end
        @(negedge Clk);
        Load  = 1'b0;
        Reset = 1'b1;
        after_pos();
        n_cmp++;
        if (DataOut !== 8'h00) begin
            n_bad++;
            $display("FAIL reset_release actual=%h required=%h", DataOut, 8'h00);
        end
    endtask

    task automatic test_load_hold();
        @(negedge Clk);
        Load   = 1'b1;
        DataIn = 8'h03;
        after_pos();
        n_cmp++;
        if (DataOut !== 8'h03) begin
            n_bad++;
            $display("FAIL load_03 actual=%h required=%h", DataOut, 8'h03);
        end
        @(negedge Clk);
        Load   = 1'b0;
        DataIn = 8'h00;
        for (int i = 0; i < 2; i++) begin
            after_pos();
            n_cmp++;
            if (DataOut !== 8'h03) begin
                n_bad++;
                $display("FAIL hold_03 edge=%0d actual=%h required=%h", i, DataOut, 8'h03);
            end
        end
    endtask

    task automatic test_async_reset();
        @(negedge Clk);
        #1;
        Reset = 1'b0;
        #1;
        n_cmp++;
        if (DataOut !== 8'h00) begin
            n_bad++;
            $display("FAIL async_reset actual=%h required=%h", DataOut, 8'h00);
        end
        #1;
        Load   = 1'b0;
        DataIn = 8'h3C;
        Reset  = 1'b1;
        after_pos();
        n_cmp++;
        if (DataOut !== 8'h00) begin
            n_bad++;
            $display("FAIL async_release_hold actual=%h required=%h", DataOut, 8'h00);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] vals [3];
        vals[0] = 8'hFF;
        vals[1] = 8'h00;
        vals[2] = 8'h5A;
        for (int i = 0; i < 3; i++) begin
            @(negedge Clk);
            Load   = 1'b1;
            DataIn = vals[i];
            after_pos();
            n_cmp++;
            if (DataOut !== vals[i]) begin
                n_bad++;
                $display("FAIL back_to_back idx=%0d actual=%h required=%h", i, DataOut, vals[i]);
            end
        end
        @(negedge Clk);
        Load = 1'b0;
    endtask

    task automatic test_reset_priority();
        @(negedge Clk);
        Reset  = 1'b0;
        Load   = 1'b1;
        DataIn = 8'h7E;
        after_pos();
        n_cmp++;
        if (DataOut !== 8'h00) begin
            n_bad++;
            $display("FAIL reset_priority actual=%h required=%h", DataOut, 8'h00);
        end
        @(negedge Clk);
        Reset = 1'b1;
        after_pos();
        n_cmp++;
        if (DataOut !== 8'h7E) begin
            n_bad++;
            $display("FAIL load_after_priority actual=%h required=%h", DataOut, 8'h7E);
        end
    endtask

    task automatic test_between_edges();
        logic [7:0] pats [4];
        pats[0] = 8'h11;
        pats[1] = 8'hEE;
        pats[2] = 8'h80;
        pats[3] = 8'h01;
        @(negedge Clk);
        for (int i = 0; i < 4; i++) begin
            #1;
            DataIn = pats[i];
            Load   = ~Load;
            n_cmp++;
            if (DataOut !== 8'h7E) begin
                n_bad++;
                $display("FAIL between_edges step=%0d actual=%h required=%h", i, DataOut, 8'h7E);
            end
        end
        Load = 1'b0;
        after_pos();
        n_cmp++;
        if (DataOut !== 8'h7E) begin
            n_bad++;
            $display("FAIL between_edges_hold actual=%h required=%h", DataOut, 8'h7E);
        end
    endtask

    task automatic test_random();
        logic [7:0] model;
        logic       hold;
        model = DataOut === 8'h7E ? 8'h7E : 8'h7E;
        for (int c = 0; c < 1000; c++) begin
            @(negedge Clk);
            Load   = 1'($urandom_range(0, 1));
            DataIn = 8'($urandom_range(0, 255));
            hold   = 1'b0;
            if ($urandom_range(0, 15) == 0) begin
                #2;
                Reset = 1'b0;
                #1;
                model = 8'h00;
                n_cmp++;
                if (DataOut !== model) begin
                    n_bad++;
                    $display("FAIL rand_async_reset cycle=%0d actual=%h required=%h", c, DataOut, model);
                end
                hold = 1'($urandom_range(0, 1));
                if (!hold) begin
                    #1;
                    Reset = 1'b1;
                end
            end
            after_pos();
            if (Reset && Load) model = DataIn;
            n_cmp++;
            if (DataOut !== model) begin
                n_bad++;
                $display("FAIL rand_edge cycle=%0d actual=%h required=%h", c, DataOut, model);
            end
            if (hold) Reset = 1'b1;
        end
    endtask

    initial begin
        n_cmp  = 0;
        n_bad  = 0;
        Reset  = 1'b1;
        Load   = 1'b0;
        DataIn = 8'h00;
        test_reset();
        test_load_hold();
        test_async_reset();
        test_back_to_back();
        test_reset_priority();
        test_between_edges();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
